exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Execute stage directly downstream of the register file. Latches operands B/C and the
//  flags register on Start, computes an ALU or iterative multiply/divide result, and
//  presents destination address, result and new flags to the register file write port.
//  Single-cycle ops finish in 1 cycle. MUL/DIV/REM run a shift-add / restoring FSM.
// PARAMETERS
//  l   16  data/register width in bits (even, >= 8)
//  a   3   register address width; flags register is address (1<<a)-1
// PORTS
//  Clk         in   1    rising-edge clock
//  RstN        in   1    asynchronous, active-low reset
//  Start       in   1    launch op; sampled only when Busy=0
//  Op          in   4    operation code (see BEHAVIOUR)
//  AddrA       in   a    destination register address, latched on Start
//  OperandB    in   l    first operand (register file OutDataB)
//  OperandC    in   l    second operand (register file OutDataC)
//  InFlags     in   l    current flags (register file OutFlags)
//  Busy        out  1    high from the cycle after accepted Start until Done
//  Done        out  1    one-cycle pulse; OutAddrA/OutDataA/OutNewFlags valid this cycle
//  OutAddrA    out  a    latched destination address
//  OutDataA    out  l    result; held until next Done
//  OutNewFlags out  l    updated flags; held until next Done
// BEHAVIOUR
//  Reset (async, RstN=0): state IDLE; Busy=0, Done=0, OutAddrA=0, OutDataA=0,
//   OutNewFlags=0; any in-flight op is aborted, no Done is produced for it.
//  Ops: 0 ADD, 1 SUB (B-C), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SRA,
//   8 MUL (low l bits, unsigned), 9 DIVU (B/C), 10 REMU (B%C), 11-15 MOV (result=B).
//   Shifts use C[$clog2(l)-1:0] as the amount; upper bits of C are ignored.
//  FSM: IDLE -> (Start, Op<8 or Op>10) DONE; IDLE -> (Start, Op 8) MUL;
//   IDLE -> (Start, Op 9/10, C!=0) DIV; IDLE -> (Start, Op 9/10, C==0) DONE;
//   MUL/DIV -> DONE after exactly l iterations (one bit per cycle); DONE -> IDLE.
//  Latency: Start at edge N. Single-cycle ops and divide-by-zero: Done at N+1.
//   MUL/DIV/REM: Done at N+l+1. Busy=1 for MUL/DIV/REM from N+1 through N+l; Busy=0 in DONE.
//  Start with Busy=1 is ignored. Start during the DONE cycle is accepted, giving
//   back-to-back issue (one op/cycle for single-cycle ops).
//  Operands, Op and AddrA are captured at Start; later input changes do not affect the op.
//  Arithmetic is modulo 2^l. Carry for ADD is the carry-out; for SUB it is the no-borrow
//   bit (B>=C unsigned). V is signed overflow for ADD/SUB, 0 otherwise.
//  Flags bit0 Z (result==0), bit1 N (result[l-1]), bit2 C (ADD/SUB/shift-out bit),
//   bit3 V, bit4 DZ (divide by zero), bit5 ILL (illegal op). All other bits copied from
//   the latched InFlags. C for SHL/SHR/SRA is the last bit shifted out (0 when amount=0).
//  Divide by zero: DIVU result all-ones, REMU result = B, DZ=1; DZ=0 on all other ops.
//  Done is a single pulse; the downstream controller uses it to commit to the register file.
// CONFIGURATION
//  EXEC_MULDIV_EN defined: ops 8-10 as above, MUL/DIV FSM states present.
//  Not defined: MUL/DIV states and datapath removed; ops 8-10 complete in 1 cycle
//   (Done at N+1), result 0, Z=1, ILL=1; Busy never asserts.
//  ILL is 0 for every other op in both builds.
// TESTING
//  Reset: RstN=0 mid-MUL -> Busy=0, Done=0, all outputs 0 asynchronously; no late Done.
//  ADD B=16'h7FFF, C=16'h0001 -> Done at N+1, OutDataA=16'h8000, N=1, V=1, C=0, Z=0.
//  SUB B=16'h0005, C=16'h0005 back-to-back with XOR B=16'hFFFF, C=16'h00FF ->
//   Done two consecutive cycles, results 0 (Z=1, C=1) then 16'hFF00 (N=1).
//  MUL B=16'd300, C=16'd300 (EXEC_MULDIV_EN) -> Done at N+17, OutDataA=16'h5F90;
//   Start asserted during Busy ignored.
//  DIVU B=16'd100, C=16'd7 -> 16'd14 at N+17; REMU same -> 16'd2; DIVU C=0 ->
//   16'hFFFF, DZ=1, at N+1.
//  Build without EXEC_MULDIV_EN: MUL 3*4 -> Done N+1, OutDataA=0, ILL=1, Busy never 1.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: ALU plus optional iterative multiply/divide.
// EXEC_MULDIV_EN enables the MUL/DIVU/REMU shift-add / restoring FSM.
module exec_unit #(
  parameter int l = 16,
  parameter int a = 3
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         Start,
  input  logic [3:0]   Op,
  input  logic [a-1:0] AddrA,
  input  logic [l-1:0] OperandB,
  input  logic [l-1:0] OperandC,
  input  logic [l-1:0] InFlags,
  output logic         Busy,
  output logic         Done,
  output logic [a-1:0] OutAddrA,
  output logic [l-1:0] OutDataA,
  output logic [l-1:0] OutNewFlags
);

  localparam int SW = $clog2(l);

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {Idle, Fin, Mul, Div} stateT;
`else
  typedef enum logic {Idle, Fin} stateT;
`endif

  stateT state;

  logic [SW-1:0] amt;
  logic [l:0]    sum;
  logic [l:0]    dif;
  logic [l:0]    shlV;
  logic [l:0]    shrV;
  logic [l:0]    sraV;
  logic [l-1:0]  aluRes;
  logic          aluC;
  logic          aluV;
  logic          aluDz;
  logic          aluIll;
  logic          goMul;
  logic          goDiv;

  function automatic logic [l-1:0] mkFlags(
    input logic [l-1:0] f,
    input logic [l-1:0] res,
    input logic         c,
    input logic         v,
    input logic         dz,
    input logic         ill
  );
    logic [l-1:0] r;
    r    = f;
    r[0] = (res == '0);
    r[1] = res[l-1];
    r[2] = c;
    r[3] = v;
    r[4] = dz;
    r[5] = ill;
    return r;
  endfunction

  assign amt  = OperandC[SW-1:0];
  assign sum  = {1'b0, OperandB} + {1'b0, OperandC};
  assign dif  = {1'b0, OperandB} - {1'b0, OperandC};
  assign shlV = {1'b0, OperandB} << amt;
  assign shrV = {OperandB, 1'b0} >> amt;
  assign sraV = $unsigned($signed({OperandB, 1'b0}) >>> amt);

  // Single-cycle result, flag inputs and iterative-op dispatch
  always_comb begin
    aluRes = OperandB;
    aluC   = 1'b0;
    aluV   = 1'b0;
    aluDz  = 1'b0;
    aluIll = 1'b0;
    goMul  = 1'b0;
    goDiv  = 1'b0;
    unique case (1'b1)
      (Op == 4'd0): begin
        aluRes = sum[l-1:0];
        aluC   = sum[l];
        aluV   = (OperandB[l-1] == OperandC[l-1]) &&
                 (sum[l-1] != OperandB[l-1]);
      end
      (Op == 4'd1): begin
        aluRes = dif[l-1:0];
        aluC   = ~dif[l];
        aluV   = (OperandB[l-1] != OperandC[l-1]) &&
                 (dif[l-1] != OperandB[l-1]);
      end
      (Op == 4'd2): aluRes = OperandB & OperandC;
      (Op == 4'd3): aluRes = OperandB | OperandC;
      (Op == 4'd4): aluRes = OperandB ^ OperandC;
      (Op == 4'd5): begin
        aluRes = shlV[l-1:0];
        aluC   = shlV[l];
      end
      (Op == 4'd6): begin
        aluRes = shrV[l:1];
        aluC   = shrV[0];
      end
      (Op == 4'd7): begin
        aluRes = sraV[l:1];
        aluC   = sraV[0];
      end
`ifdef EXEC_MULDIV_EN
      (Op == 4'd8): goMul = 1'b1;
      (Op == 4'd9): begin
        if (OperandC == '0) begin
          aluRes = '1;
          aluDz  = 1'b1;
        end else begin
          goDiv = 1'b1;
        end
      end
      (Op == 4'd10): begin
        if (OperandC == '0) begin
          aluRes = OperandB;
          aluDz  = 1'b1;
        end else begin
          goDiv = 1'b1;
        end
      end
`else
      (Op >= 4'd8 && Op <= 4'd10): begin
        aluRes = '0;
        aluIll = 1'b1;
      end
`endif
      default: aluRes = OperandB;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  logic [l-1:0]  accR;
  logic [l-1:0]  opB;
  logic [l-1:0]  opC;
  logic [l-1:0]  flagsR;
  logic [a-1:0]  addrR;
  logic [SW-1:0] cnt;
  logic          isRem;
  logic [l-1:0]  mulAcc;
  logic [l:0]    divTmp;
  logic [l:0]    divDif;
  logic [l-1:0]  remN;
  logic [l-1:0]  quoN;
  logic [l-1:0]  divRes;
  logic          lastIt;

  assign mulAcc = opC[0] ? accR + opB : accR;
  assign divTmp = {accR, opB[l-1]};
  assign divDif = divTmp - {1'b0, opC};
  assign remN   = divDif[l] ? divTmp[l-1:0] : divDif[l-1:0];
  assign quoN   = {opB[l-2:0], ~divDif[l]};
  assign divRes = isRem ? remN : quoN;
  assign lastIt = (cnt == SW'(l - 1));
  assign Busy   = (state == Mul) || (state == Div);
`else
  assign Busy = 1'b0;
`endif

  // Control FSM, iterative datapath and registered write-port outputs
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state       <= Idle;
      Done        <= 1'b0;
      OutAddrA    <= '0;
      OutDataA    <= '0;
      OutNewFlags <= '0;
`ifdef EXEC_MULDIV_EN
      accR   <= '0;
      opB    <= '0;
      opC    <= '0;
      flagsR <= '0;
      addrR  <= '0;
      cnt    <= '0;
      isRem  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      unique case (state)
        Idle, Fin: begin
          state <= Idle;
          if (Start) begin
`ifdef EXEC_MULDIV_EN
            flagsR <= InFlags;
            addrR  <= AddrA;
            if (goMul || goDiv) begin
              state <= goMul ? Mul : Div;
              accR  <= '0;
              opB   <= OperandB;
              opC   <= OperandC;
              cnt   <= '0;
              isRem <= (Op == 4'd10);
            end else
`endif
            begin
              state       <= Fin;
              Done        <= 1'b1;
              OutAddrA    <= AddrA;
              OutDataA    <= aluRes;
              OutNewFlags <= mkFlags(InFlags, aluRes, aluC,
                                     aluV, aluDz, aluIll);
            end
          end
        end
`ifdef EXEC_MULDIV_EN
        Mul: begin
          accR <= mulAcc;
          opB  <= opB << 1;
          opC  <= opC >> 1;
          cnt  <= cnt + 1'b1;
          if (lastIt) begin
            state       <= Fin;
            Done        <= 1'b1;
            OutAddrA    <= addrR;
            OutDataA    <= mulAcc;
            OutNewFlags <= mkFlags(flagsR, mulAcc, 1'b0,
                                   1'b0, 1'b0, 1'b0);
          end
        end
        Div: begin
          accR <= remN;
          opB  <= quoN;
          cnt  <= cnt + 1'b1;
          if (lastIt) begin
            state       <= Fin;
            Done        <= 1'b1;
            OutAddrA    <= addrR;
            OutDataA    <= divRes;
            OutNewFlags <= mkFlags(flagsR, divRes, 1'b0,
                                   1'b0, 1'b0, 1'b0);
          end
        end
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed vectors, queued expectations,
// monitor pops and compares on each Done pulse.
module tb_exec_unit;
  localparam int L = 16;
  localparam int A = 3;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         Start = 1'b0;
  logic [3:0]   Op = '0;
  logic [A-1:0] AddrA = '0;
  logic [L-1:0] OperandB = '0;
  logic [L-1:0] OperandC = '0;
  logic [L-1:0] InFlags = '0;
  logic         Busy;
  logic         Done;
  logic [A-1:0] OutAddrA;
  logic [L-1:0] OutDataA;
  logic [L-1:0] OutNewFlags;

  typedef struct {
    int           cyc;
    logic [A-1:0] addr;
    logic [L-1:0] data;
    logic [L-1:0] flags;
  } expT;

  expT sb[$];
  int  cyc = 0;
  int  nTests = 0;
  int  nFail = 0;
  int  k;
  bit  busySeen = 1'b0;

  exec_unit #(.l(L), .a(A)) dut (
    .Clk(Clk),
    .RstN(RstN),
    .Start(Start),
    .Op(Op),
    .AddrA(AddrA),
    .OperandB(OperandB),
    .OperandC(OperandC),
    .InFlags(InFlags),
    .Busy(Busy),
    .Done(Done),
    .OutAddrA(OutAddrA),
    .OutDataA(OutDataA),
    .OutNewFlags(OutNewFlags)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest expectation
  always @(negedge Clk) begin
    expT e;
    if (Busy === 1'b1) busySeen = 1'b1;
    if (Done !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, Done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("out_addr", {29'b0, OutAddrA}, {29'b0, e.addr});
        chk("out_data", {16'b0, OutDataA}, {16'b0, e.data});
        chk("out_flags", {16'b0, OutNewFlags}, {16'b0, e.flags});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [A-1:0] ad,
                       input logic [L-1:0] b, input logic [L-1:0] c,
                       input logic [L-1:0] ed, input logic [L-1:0] ef,
                       input int lat, input bit push);
    expT e;
    Start    = 1'b1;
    Op       = op;
    AddrA    = ad;
    OperandB = b;
    OperandC = c;
    InFlags  = 16'hF0FF;
    if (push) begin
      e.cyc   = cyc + lat;
      e.addr  = ad;
      e.data  = ed;
      e.flags = ef;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    Op       = 4'hF;
    AddrA    = '1;
    OperandB = '1;
    OperandC = '1;
    InFlags  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge Clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RstN = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_addr", {29'b0, OutAddrA}, 32'd0);
    chk("rst_data", {16'b0, OutDataA}, 32'd0);
    chk("rst_flags", {16'b0, OutNewFlags}, 32'd0);
    RstN = 1'b1;
    @(posedge Clk);
    #1;

    issue(4'd0, 3'd1, 16'h7FFF, 16'h0001, 16'h8000, 16'hF0CA, 1, 1'b1);
    issue(4'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 16'hF0C5, 1, 1'b1);
    issue(4'd4, 3'd3, 16'hFFFF, 16'h00FF, 16'hFF00, 16'hF0C2, 1, 1'b1);
    issue(4'd2, 3'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'hF0C0, 1, 1'b1);
    issue(4'd3, 3'd5, 16'h1200, 16'h0034, 16'h1234, 16'hF0C0, 1, 1'b1);
    issue(4'd5, 3'd6, 16'h8001, 16'h0011, 16'h0002, 16'hF0C4, 1, 1'b1);
    issue(4'd6, 3'd0, 16'h0003, 16'h0002, 16'h0000, 16'hF0C5, 1, 1'b1);
    issue(4'd7, 3'd1, 16'h8000, 16'h0004, 16'hF800, 16'hF0C2, 1, 1'b1);
    issue(4'd5, 3'd2, 16'h8001, 16'h0010, 16'h8001, 16'hF0C2, 1, 1'b1);
    issue(4'd12, 3'd3, 16'h0000, 16'h5555, 16'h0000, 16'hF0C1, 1, 1'b1);
    issue(4'd0, 3'd4, 16'hFFFF, 16'h0001, 16'h0000, 16'hF0C5, 1, 1'b1);
    issue(4'd1, 3'd5, 16'h0003, 16'h0005, 16'hFFFE, 16'hF0C2, 1, 1'b1);
    issue(4'd1, 3'd6, 16'h8000, 16'h0001, 16'h7FFF, 16'hF0CC, 1, 1'b1);
    drain();

`ifdef EXEC_MULDIV_EN
    k = cyc;
    issue(4'd8, 3'd2, 16'd300, 16'd300, 16'h5F90, 16'hF0C0, 17, 1'b1);
    chk("busy_after_start", {31'b0, Busy}, 32'd1);
    Start    = 1'b1;
    Op       = 4'd0;
    AddrA    = 3'd7;
    OperandB = 16'h0001;
    OperandC = 16'h0001;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (k + 16 - cyc) @(posedge Clk);
    #1;
    chk("busy_last_iter", {31'b0, Busy}, 32'd1);
    @(posedge Clk);
    #1;
    chk("busy_in_done", {31'b0, Busy}, 32'd0);
    drain();

    issue(4'd9, 3'd3, 16'd100, 16'd7, 16'd14, 16'hF0C0, 17, 1'b1);
    drain();
    issue(4'd10, 3'd4, 16'd100, 16'd7, 16'd2, 16'hF0C0, 17, 1'b1);
    drain();
    issue(4'd9, 3'd5, 16'd100, 16'd0, 16'hFFFF, 16'hF0D2, 1, 1'b1);
    issue(4'd10, 3'd6, 16'h1234, 16'd0, 16'h1234, 16'hF0D0, 1, 1'b1);
    drain();

    issue(4'd8, 3'd1, 16'd300, 16'd300, 16'h0, 16'h0, 17, 1'b0);
    repeat (5) @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
`else
    k = cyc;
    issue(4'd8, 3'd2, 16'd3, 16'd4, 16'h0000, 16'hF0E1, 1, 1'b1);
    issue(4'd9, 3'd3, 16'd10, 16'd2, 16'h0000, 16'hF0E1, 1, 1'b1);
    issue(4'd10, 3'd4, 16'd10, 16'd3, 16'h0000, 16'hF0E1, 1, 1'b1);
    drain();
    chk("busy_never", {31'b0, busySeen}, 32'd0);

    issue(4'd0, 3'd5, 16'h0001, 16'h0001, 16'h0002, 16'hF0C0, 1, 1'b1);
    drain();
    @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
`endif
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    chk("abort_addr", {29'b0, OutAddrA}, 32'd0);
    chk("abort_data", {16'b0, OutDataA}, 32'd0);
    chk("abort_flags", {16'b0, OutNewFlags}, 32'd0);
    @(posedge Clk);
    #1;
    RstN = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    chk("idle_after_abort", {31'b0, Busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
